// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment types, segment bit indices and hex glyph table
//
// Purpose: single source of the hex glyph encoding used by the decoder and
// anything else that needs to name individual segments.
// Ports: none (package).
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-high glyphs for 0..F, bit0 = segment a.
  localparam seg7_t SEG7_PATTERN [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - display data/control bundle between datapath and scan driver
//
// Purpose: groups the display request side (en/value/dp/blank/load) and the
// scanned display side (seg/dp_out/an/digit_idx/frame_done/updated).
// Modports:
//   master : drives en, value, dp, blank, load; observes the display outputs
//   slave  : the scan driver; consumes the request side, drives the outputs
interface seg7_scan_driver_if
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                 en;
  logic [4*DIGITS-1:0]  value;
  logic [DIGITS-1:0]    dp;
  logic [DIGITS-1:0]    blank;
  logic                 load;
  seg7_t                seg;
  logic                 dp_out;
  logic [DIGITS-1:0]    an;
  logic [IDX_W-1:0]     digit_idx;
  logic                 frame_done;
  logic                 updated;

  modport master (
    output en, value, dp, blank, load,
    input  seg, dp_out, an, digit_idx, frame_done, updated
  );

  modport slave (
    input  en, value, dp, blank, load,
    output seg, dp_out, an, digit_idx, frame_done, updated
  );

endinterface

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// rtl/seg7_scan_driver_hex_to_seg7.sv - combinational hex nibble to 7-segment glyph decoder
//
// Purpose: looks up the active-high glyph for one hex nibble.
// Ports:
//   i_nib : 4-bit hex digit
//   o_seg : active-high segment pattern, bit0 = a .. bit6 = g
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output seg7_t      o_seg
);

  assign o_seg = SEG7_PATTERN[i_nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed multi-digit 7-segment scan driver
//
// Purpose: scans DIGITS hex digits onto a shared segment bus, one digit slot
// of PRESCALE clocks each, with an all-anodes-off dead time at the start of
// every slot. New display data is staged on load and only committed to the
// shadow registers at a frame boundary, so a frame never mixes old and new data.
// Ports:
//   clk : system clock
//   rst : synchronous reset, active-high
//   bus : seg7_scan_driver_if.slave (en, value, dp, blank, load in;
//         seg, dp_out, an, digit_idx, frame_done, updated out)
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 1000,
  parameter int DEAD_CYCLES    = 1,
  parameter int LZ_SUPPRESS    = 0,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
)
(
  input  logic                 clk,
  input  logic                 rst,
  seg7_scan_driver_if.slave    bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(PRESCALE);

  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0]  DEAD_END = PRE_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(DIGITS - 1);

  // XOR masks that turn active-high internal values into pin polarity;
  // they are also the "inactive" pin levels.
  localparam seg7_t             SEG_OFF = {7{SEG_ACTIVE_LOW != 0}};
  localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_ACTIVE_LOW != 0}};

  logic [PRE_W-1:0]     r_pre;
  logic [IDX_W-1:0]     r_idx;
  logic [4*DIGITS-1:0]  r_stg_val;
  logic [DIGITS-1:0]    r_stg_dp;
  logic [DIGITS-1:0]    r_stg_blank;
  logic [4*DIGITS-1:0]  r_sh_val;
  logic [DIGITS-1:0]    r_sh_dp;
  logic [DIGITS-1:0]    r_sh_blank;
  logic                 r_pending;
  seg7_t                r_seg;
  logic                 r_dp_out;
  logic [DIGITS-1:0]    r_an;
  logic                 r_updated;

  logic                 w_frame_done;
  logic                 w_commit;
  logic                 w_dead;
  logic [DIGITS-1:0]    w_lz;
  logic [DIGITS-1:0]    w_hot;
  logic [3:0]           w_nib;
  logic                 w_dark;
  logic                 w_dp;
  seg7_t                w_pattern;

  // Frame ends on the last clock of the last digit's slot; gated by rst so
  // no pulse escapes while the block is held in reset.
  assign w_frame_done = !rst && bus.en && (r_pre == PRE_MAX) && (r_idx == IDX_MAX);
  assign w_commit     = w_frame_done && r_pending;
  assign w_dead       = (r_pre < DEAD_END);

  // Leading-zero mask: walk from the most significant digit down, keeping a
  // running "everything above and including me is zero" flag.
  always_comb begin : lz_mask
    logic v_run;
    v_run = 1'b1;
    w_lz  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v_run   = v_run && (r_sh_val[i*4 +: 4] == 4'h0);
      w_lz[i] = (LZ_SUPPRESS != 0) && (i > 0) && v_run;
    end
  end

  // Select the current digit's shadow data and its one-hot anode.
  always_comb begin
    w_nib  = 4'h0;
    w_dark = 1'b0;
    w_dp   = 1'b0;
    w_hot  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib    = r_sh_val[i*4 +: 4];
        w_dark   = r_sh_blank[i] || w_lz[i];
        w_dp     = r_sh_dp[i];
        w_hot[i] = 1'b1;
      end
    end
  end

  hex_to_seg7 u_dec (
    .i_nib (w_nib),
    .o_seg (w_pattern)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre       <= '0;
      r_idx       <= '0;
      r_stg_val   <= '0;
      r_stg_dp    <= '0;
      r_stg_blank <= '0;
      r_sh_val    <= '0;
      r_sh_dp     <= '0;
      r_sh_blank  <= '0;
      r_pending   <= 1'b0;
      r_seg       <= SEG_OFF;
      r_dp_out    <= DP_OFF;
      r_an        <= AN_OFF;
      r_updated   <= 1'b0;
    end else begin
      if (bus.en) begin
        if (r_pre == PRE_MAX) begin
          r_pre <= '0;
          r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
        end else begin
          r_pre <= r_pre + 1'b1;
        end
      end

      if (bus.load) begin
        r_stg_val   <= bus.value;
        r_stg_dp    <= bus.dp;
        r_stg_blank <= bus.blank;
      end

      // Shadow takes the staging contents as they were before this edge, so a
      // load coinciding with the commit stays pending for the next frame.
      if (w_commit) begin
        r_sh_val   <= r_stg_val;
        r_sh_dp    <= r_stg_dp;
        r_sh_blank <= r_stg_blank;
      end
      r_pending <= bus.load || (r_pending && !w_commit);
      r_updated <= w_commit;

      r_an     <= (bus.en && !w_dead) ? (w_hot ^ AN_OFF) : AN_OFF;
      r_seg    <= (w_dark ? 7'h00 : w_pattern) ^ SEG_OFF;
      r_dp_out <= (!w_dark && w_dp) ^ DP_OFF;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.dp_out     = r_dp_out;
  assign bus.an         = r_an;
  assign bus.digit_idx  = r_idx;
  assign bus.frame_done = w_frame_done;
  assign bus.updated    = r_updated;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [15:0] value = '0;
  logic [3:0] dp = '0;
  logic [3:0] blank = '0;
  logic load = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.DIGITS(4)) bus0 ();
  seg7_scan_driver_if #(.DIGITS(4)) bus1 ();

  assign bus0.en = en;
  assign bus0.value = value;
  assign bus0.dp = dp;
  assign bus0.blank = blank;
  assign bus0.load = load;
  assign bus1.en = en;
  assign bus1.value = value;
  assign bus1.dp = dp;
  assign bus1.blank = blank;
  assign bus1.load = load;

  seg7_scan_driver #(.DIGITS(4), .PRESCALE(4), .DEAD_CYCLES(1), .LZ_SUPPRESS(0),
                     .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

  seg7_scan_driver #(.DIGITS(4), .PRESCALE(4), .DEAD_CYCLES(1), .LZ_SUPPRESS(1),
                     .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frame position 0..15 = digit*4 + clock-within-slot.
  logic [6:0] PAT [16];
  initial PAT = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int m_pos = 0;
  logic [15:0] m_sv = '0, m_gv = '0;
  logic [3:0] m_sdp = '0, m_sbl = '0, m_gdp = '0, m_gbl = '0;
  bit m_pend = 1'b0;
  logic [3:0] e_an = '0;
  logic [6:0] e_seg0 = '0, e_seg1 = '0;
  logic e_dp0 = 1'b0, e_dp1 = 1'b0;
  bit e_upd = 1'b0;

  // Returns {dp, seg} for digit d from the model's shadow data.
  function automatic logic [7:0] exp_digit(input int d, input bit lz);
    int nib;
    bit dark;
    nib = int'((m_sv >> (4 * d)) & 16'h000F);
    dark = m_sbl[d] || (lz && d > 0 && (m_sv >> (4 * d)) == 16'h0);
    if (dark) return 8'h00;
    return {m_sdp[d], PAT[nib]};
  endfunction

  always @(posedge clk) begin
    int d;
    int ph;
    bit fd;
    logic [7:0] r0;
    logic [7:0] r1;
    d = m_pos / 4;
    ph = m_pos % 4;
    if (rst) begin
      m_pos = 0;
      m_sv = '0; m_sdp = '0; m_sbl = '0;
      m_pend = 1'b0;
      e_an = '0; e_seg0 = '0; e_seg1 = '0; e_dp0 = 1'b0; e_dp1 = 1'b0;
      e_upd = 1'b0;
    end else begin
      e_an = (en && ph >= 1) ? 4'(1 << d) : 4'h0;
      r0 = exp_digit(d, 1'b0);
      r1 = exp_digit(d, 1'b1);
      e_seg0 = r0[6:0]; e_dp0 = r0[7];
      e_seg1 = r1[6:0]; e_dp1 = r1[7];
      fd = en && (m_pos == 15);
      e_upd = fd && m_pend;
      if (fd && m_pend) begin
        m_sv = m_gv; m_sdp = m_gdp; m_sbl = m_gbl;
        m_pend = 1'b0;
      end
      if (load) begin
        m_gv = value; m_gdp = dp; m_gbl = blank;
        m_pend = 1'b1;
      end
      if (en) m_pos = (m_pos + 1) % 16;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("an0", 16'(bus0.an), 16'(e_an));
      chk("an1", 16'(bus1.an), 16'(e_an));
      chk("seg0", 16'(bus0.seg), 16'(e_seg0));
      chk("seg1", 16'(bus1.seg), 16'(e_seg1));
      chk("dp0", 16'(bus0.dp_out), 16'(e_dp0));
      chk("dp1", 16'(bus1.dp_out), 16'(e_dp1));
      chk("idx0", 16'(bus0.digit_idx), 16'(m_pos / 4));
      chk("idx1", 16'(bus1.digit_idx), 16'(m_pos / 4));
      chk("fd0", 16'(bus0.frame_done), 16'(!rst && en && m_pos == 15));
      chk("upd0", 16'(bus0.updated), 16'(e_upd));
      chk("upd1", 16'(bus1.updated), 16'(e_upd));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_pulse(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp = d; blank = b; load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  task automatic wait_upd();
    bit got;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = bus0.updated;
    end
    if (!got) chk("upd_timeout", 16'd0, 16'd1);
  endtask

  // Called right after the updated pulse is seen: walks one whole frame.
  task automatic chk_slots(input int sel, input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpm);
    logic [6:0] s [4];
    s = '{s0, s1, s2, s3};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("slot_dead", 16'(sel == 0 ? bus0.an : bus1.an), 16'h0);
      @(negedge clk);
      chk("slot_an", 16'(sel == 0 ? bus0.an : bus1.an), 16'(1 << k));
      chk("slot_seg", 16'(sel == 0 ? bus0.seg : bus1.seg), 16'(s[k]));
      chk("slot_dp", 16'(sel == 0 ? bus0.dp_out : bus1.dp_out), 16'(dpm[k]));
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    int cnt;
    bit got;
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    tick(2);
    // reset state
    @(negedge clk);
    chk("rst_an", 16'(bus0.an), 16'h0);
    chk("rst_seg", 16'(bus0.seg), 16'h0);
    chk("rst_dp", 16'(bus0.dp_out), 16'h0);
    chk("rst_idx", 16'(bus0.digit_idx), 16'h0);
    chk("rst_fd", 16'(bus0.frame_done), 16'h0);
    chk("rst_upd", 16'(bus0.updated), 16'h0);

    // 1: first load commits at first frame end
    @(posedge clk);
    #1;
    rst = 1'b0;
    en = 1'b1;
    load_pulse(16'h1234, 4'h0, 4'h0);
    wait_upd();
    chk_slots(0, 7'h66, 7'h4F, 7'h5B, 7'h06, 4'h0);

    // 2: frame period
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = bus0.frame_done;
    end
    chk("fd_seen", 16'(got), 16'd1);
    for (int r = 0; r < 3; r++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!bus0.frame_done && cnt < 40);
      chk("fd_period", 16'(cnt), 16'd16);
    end

    // 3: mid-frame load, tear-free
    @(posedge clk);
    #1;
    tick(5);
    load_pulse(16'hABCD, 4'h0, 4'h0);
    wait_upd();
    chk_slots(0, 7'h5E, 7'h39, 7'h7C, 7'h77, 4'h0);

    // 4: leading-zero suppression (instance 1)
    @(posedge clk);
    #1;
    load_pulse(16'h0070, 4'b0001, 4'h0);
    wait_upd();
    chk_slots(1, 7'h3F, 7'h07, 7'h00, 7'h00, 4'b0001);
    @(posedge clk);
    #1;
    load_pulse(16'h0000, 4'h0, 4'h0);
    wait_upd();
    chk_slots(1, 7'h3F, 7'h00, 7'h00, 7'h00, 4'h0);

    // blanking and dp on instance 0
    @(posedge clk);
    #1;
    load_pulse(16'h1234, 4'b1000, 4'b0100);
    wait_upd();
    chk_slots(0, 7'h66, 7'h4F, 7'h00, 7'h06, 4'b1000);

    // 5: freeze mid-slot
    @(posedge clk);
    #1;
    tick(6);
    en = 1'b0;
    tick(10);
    @(negedge clk);
    chk("frz_an", 16'(bus0.an), 16'h0);
    chk("frz_fd", 16'(bus0.frame_done), 16'h0);
    @(posedge clk);
    #1;
    en = 1'b1;
    tick(20);

    // 6: pending load discarded by reset
    load_pulse(16'h5555, 4'hF, 4'h0);
    tick(1);
    rst = 1'b1;
    tick(1);
    @(negedge clk);
    chk("rst2_an", 16'(bus0.an), 16'h0);
    chk("rst2_seg", 16'(bus0.seg), 16'h0);
    chk("rst2_fd", 16'(bus0.frame_done), 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus0.updated) cnt++;
    end
    chk("no_upd_after_rst", 16'(cnt), 16'd0);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
